uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It oversamples the asynchronous line `din` with the system clock and reassembles each byte on `data_rx`. It sits at the RX pin of the design and signals each completed frame with a one-cycle `valid` pulse. Internal `index`, `state` and `counter` are exported as debug ports.

---
 rtl/uart_receiver_if.sv | 31 +++
 rtl/uart_receiver.sv | 143 ++++++++++++++
 tb/tb_uart_receiver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: bundles the serial input line, the received byte with its
// valid strobe, and the debug taps of the UART receiver.
// slave  : the receiver side (samples din, drives everything else)
// master : the side that drives the line and consumes the received bytes
`timescale 1ns/1ps
interface uart_receiver_if;
  logic       din;
  logic [7:0] data_rx;
  logic       valid;
  logic [2:0] index;
  logic [1:0] state;
  logic [8:0] counter;

  modport slave (
    input  din,
    output data_rx,
    output valid,
    output index,
    output state,
    output counter
  );

  modport master (
    output din,
    input  data_rx,
    input  valid,
    input  index,
    input  state,
    input  counter
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver (1 start, 8 data LSB first, 1 stop bit).
// The line is oversampled with the system clock; each bit is sampled at its
// centre, and a correct stop bit produces a one-cycle registered valid pulse.
// Optional feature: define UART_RX_SYNC_EN to pass din through a two-flop
// synchronizer (reset to idle-high) before the FSM; this adds 2 cycles of
// latency to every event. Without it din must already be synchronous to clk.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLKS_PER_BIT = 278   // legal range 4..511
) (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave rx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Last counter value of the half bit (start-bit centre) and of a full bit.
  localparam logic [8:0] HALF_LAST = 9'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);

  logic din_s;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer next values: a plain two-stage shift of the raw line.
  always_comb begin
    sync1_d = rx.din;
    sync2_d = sync1_q;
  end

  // Synchronizer flops reset to the idle-high line level so no false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = rx.din;
`endif

  state_t     state_q,   state_d;
  logic [8:0] counter_q, counter_d;
  logic [2:0] index_q,   index_d;
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;

  // Next-state and datapath logic; everything holds unless a case updates it.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    index_d   = index_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        counter_d = 9'd0;
        index_d   = 3'd0;
        if (din_s == 1'b0) begin
          state_d = START;
        end
      end

      START: begin
        if (counter_q == HALF_LAST) begin
          // Middle of the start bit: a high line here was only a glitch.
          counter_d = 9'd0;
          state_d   = (din_s == 1'b0) ? DATA : IDLE;
        end else begin
          counter_d = counter_q + 9'd1;
        end
      end

      DATA: begin
        if (counter_q == BIT_LAST) begin
          counter_d       = 9'd0;
          data_d[index_q] = din_s;
          if (index_q == 3'd7) begin
            index_d = 3'd0;
            state_d = STOP;
          end else begin
            index_d = index_q + 3'd1;
          end
        end else begin
          counter_d = counter_q + 9'd1;
        end
      end

      STOP: begin
        if (counter_q == BIT_LAST) begin
          // A low stop bit is a framing error: drop the frame silently.
          counter_d = 9'd0;
          valid_d   = din_s;
          state_d   = IDLE;
        end else begin
          counter_d = counter_q + 9'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, received byte and valid strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= 9'd0;
      index_q   <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      index_q   <= index_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign rx.data_rx = data_q;
  assign rx.valid   = valid_q;
  assign rx.index   = index_q;
  assign rx.state   = state_q;
  assign rx.counter = counter_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver with a
// scoreboard of expected bytes, consumed whenever valid pulses.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CPB = 278;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = CPB / 2 + 9 * CPB + SYNC_LAT;   // 2641 (+2)

  logic clk;
  logic rst;
  uart_receiver_if rx_if();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_valid_cyc = 0;
  int n_valid = 0;
  int n_expected = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #15.625 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse must be expected, match, and last one cycle.
  always @(negedge clk) begin
    if (rx_if.valid === 1'b1) begin
      logic [7:0] e;
      last_valid_cyc = cyc;
      n_valid++;
      chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      chk("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_rx", {24'd0, rx_if.data_rx}, {24'd0, e});
      end
    end
    prev_valid = rx_if.valid;
  end

  task automatic hold_bit(input logic b);
    rx_if.din = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Drives one full frame from a negedge; good stop bits queue the byte.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    if (stop_v) begin
      exp_q.push_back(b);
      n_expected++;
    end
    rx_if.din = 1'b0;
    @(posedge clk);
    #1 start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_v);
    rx_if.din = 1'b1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx_if.din = 1'b1;

    // Reset with the line idle.
    #20;
    chk("rst_state",   {30'd0, rx_if.state},   32'd0);
    chk("rst_counter", {23'd0, rx_if.counter}, 32'd0);
    chk("rst_index",   {29'd0, rx_if.index},   32'd0);
    chk("rst_data",    {24'd0, rx_if.data_rx}, 32'd0);
    chk("rst_valid",   {31'd0, rx_if.valid},   32'd0);
    #20 rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_state",   {30'd0, rx_if.state},   32'd0);
    chk("idle_counter", {23'd0, rx_if.counter}, 32'd0);
    chk("idle_data",    {24'd0, rx_if.data_rx}, 32'd0);

    // Single byte with latency check.
    send_frame(8'h2A, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("latency_2A", last_valid_cyc - start_cyc, LAT);
    chk("hold_2A", {24'd0, rx_if.data_rx}, 32'h2A);

    // Glitch on the start bit.
    rx_if.din = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_in_start", {30'd0, rx_if.state}, 32'd1);
    repeat (40) @(negedge clk);
    rx_if.din = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_idle", {30'd0, rx_if.state}, 32'd0);
    chk("glitch_data", {24'd0, rx_if.data_rx}, 32'h2A);

    // Framing error, then a good frame.
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("frame_err_idle", {30'd0, rx_if.state}, 32'd0);
    chk("frame_err_data", {24'd0, rx_if.data_rx}, 32'h55);
    send_frame(8'hA5, 1'b1);
    repeat (CPB) @(negedge clk);

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("b2b_last", {24'd0, rx_if.data_rx}, 32'hFF);

    // Asynchronous reset during data bit 4.
    rx_if.din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) hold_bit(i[0]);
    rx_if.din = 1'b1;
    repeat (100) @(negedge clk);
    chk("pre_rst_index", {29'd0, rx_if.index}, 32'd4);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_state",   {30'd0, rx_if.state},   32'd0);
    chk("mid_rst_counter", {23'd0, rx_if.counter}, 32'd0);
    chk("mid_rst_index",   {29'd0, rx_if.index},   32'd0);
    chk("mid_rst_data",    {24'd0, rx_if.data_rx}, 32'd0);
    chk("mid_rst_valid",   {31'd0, rx_if.valid},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_if.din = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("latency_3C", last_valid_cyc - start_cyc, LAT);

    // Everything queued must have been consumed, and nothing extra produced.
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("valid_count", n_valid, n_expected);
    chk("final_valid_low", {31'd0, rx_if.valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
